// File: rtl/cgra_cfg_sequencer_if.sv
// rtl/cgra_cfg_sequencer_if.sv - host-side config write and run-control bundle for cgra_cfg_sequencer
// Ports (slave = sequencer side):
//   cfg_valid/cfg_ready  write handshake; cfg_sel/cfg_ctx/cfg_word/cfg_data address and slice data
//   cfg_err              one-cycle pulse after an accepted illegal write
//   run_req/run_len/loop_count/stop  replay control
//   busy/done/cur_ctx    replay status
interface cgra_cfg_sequencer_if #(
  parameter int CTX_AW = 4
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [3:0]        cfg_sel;
  logic [CTX_AW-1:0] cfg_ctx;
  logic [1:0]        cfg_word;
  logic [31:0]       cfg_data;
  logic              cfg_err;
  logic              run_req;
  logic [CTX_AW-1:0] run_len;
  logic [7:0]        loop_count;
  logic              stop;
  logic              busy;
  logic              done;
  logic [CTX_AW-1:0] cur_ctx;

  modport master (
    output cfg_valid, cfg_sel, cfg_ctx, cfg_word, cfg_data,
    output run_req, run_len, loop_count, stop,
    input  cfg_ready, cfg_err, busy, done, cur_ctx
  );

  modport slave (
    input  cfg_valid, cfg_sel, cfg_ctx, cfg_word, cfg_data,
    input  run_req, run_len, loop_count, stop,
    output cfg_ready, cfg_err, busy, done, cur_ctx
  );
endinterface

// File: rtl/cgra_cfg_sequencer.sv
// rtl/cgra_cfg_sequencer.sv - stores CGRA configuration contexts and replays them into the 3x3 array
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   bus (slave)          config write port and run control/status
//   start                array execute strobe, high on every replayed context
//   PE1_data..PE9_data   PE config words of the context being driven
//   AGU0_data..AGU2_data AGU config words of the context being driven
module cgra_cfg_sequencer #(
  parameter int PE_DATA_WIDTH  = 121,
  parameter int AGU_DATA_WIDTH = 29,
  parameter int NUM_CTX        = 16,
  parameter int CTX_AW         = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  cgra_cfg_sequencer_if.slave       bus,
  output logic                      start,
  output logic [PE_DATA_WIDTH-1:0]  PE1_data,
  output logic [PE_DATA_WIDTH-1:0]  PE2_data,
  output logic [PE_DATA_WIDTH-1:0]  PE3_data,
  output logic [PE_DATA_WIDTH-1:0]  PE4_data,
  output logic [PE_DATA_WIDTH-1:0]  PE5_data,
  output logic [PE_DATA_WIDTH-1:0]  PE6_data,
  output logic [PE_DATA_WIDTH-1:0]  PE7_data,
  output logic [PE_DATA_WIDTH-1:0]  PE8_data,
  output logic [PE_DATA_WIDTH-1:0]  PE9_data,
  output logic [AGU_DATA_WIDTH-1:0] AGU0_data,
  output logic [AGU_DATA_WIDTH-1:0] AGU1_data,
  output logic [AGU_DATA_WIDTH-1:0] AGU2_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CTX_AW:0]   CTX_LIMIT = (CTX_AW+1)'(NUM_CTX);
  localparam logic [CTX_AW-1:0] CTX_LAST  = CTX_AW'(NUM_CTX - 1);

  state_t                    state;
  logic [CTX_AW-1:0]         ctx_ptr;
  logic [CTX_AW-1:0]         len_q;
  logic [7:0]                loops_q;
  logic [7:0]                iter_cnt;
  logic                      start_r;
  logic                      done_r;
  logic                      cfg_err_r;
  logic [PE_DATA_WIDTH-1:0]  pe_q  [9];
  logic [AGU_DATA_WIDTH-1:0] agu_q [3];

  // Context storage deliberately has no reset so loaded contexts survive RST.
  logic [PE_DATA_WIDTH-1:0]  pe_mem  [NUM_CTX][9];
  logic [AGU_DATA_WIDTH-1:0] agu_mem [NUM_CTX][3];

  logic                      wr_acc;
  logic                      wr_illegal;
  logic                      pe_we;
  logic                      agu_we;
  logic [3:0]                pe_idx;
  logic [1:0]                agu_idx;
  logic [PE_DATA_WIDTH-1:0]  pe_wr_val;
  logic [AGU_DATA_WIDTH-1:0] agu_wr_val;
  logic                      last_in_iter;
  logic                      final_iter;
  logic [CTX_AW-1:0]         ld_ctx;
  logic [CTX_AW-1:0]         len_clamped;
  logic [PE_DATA_WIDTH-1:0]  ld_pe  [9];
  logic [AGU_DATA_WIDTH-1:0] ld_agu [3];

  assign bus.cfg_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.cfg_err   = cfg_err_r;
  assign bus.cur_ctx   = ctx_ptr;
  assign start         = start_r;

  assign PE1_data  = pe_q[0];
  assign PE2_data  = pe_q[1];
  assign PE3_data  = pe_q[2];
  assign PE4_data  = pe_q[3];
  assign PE5_data  = pe_q[4];
  assign PE6_data  = pe_q[5];
  assign PE7_data  = pe_q[6];
  assign PE8_data  = pe_q[7];
  assign PE9_data  = pe_q[8];
  assign AGU0_data = agu_q[0];
  assign AGU1_data = agu_q[1];
  assign AGU2_data = agu_q[2];

  assign wr_acc     = bus.cfg_valid && bus.cfg_ready;
  assign wr_illegal = (bus.cfg_sel > 4'd11)
                   || ((bus.cfg_sel >= 4'd9) && (bus.cfg_word != 2'd0))
                   || ({1'b0, bus.cfg_ctx} >= CTX_LIMIT);
  assign pe_we      = wr_acc && !wr_illegal && (bus.cfg_sel < 4'd9);
  assign agu_we     = wr_acc && !wr_illegal && (bus.cfg_sel >= 4'd9);
  assign pe_idx     = (bus.cfg_sel < 4'd9) ? bus.cfg_sel : 4'd0;
  assign agu_idx    = ((bus.cfg_sel >= 4'd9) && (bus.cfg_sel <= 4'd11)) ? 2'(bus.cfg_sel - 4'd9) : 2'd0;
  assign agu_wr_val = bus.cfg_data[AGU_DATA_WIDTH-1:0];

  // Read-modify-write of one 32-bit slice; the top slice is clipped to the word width.
  always_comb begin
    pe_wr_val = pe_mem[bus.cfg_ctx][pe_idx];
    case (bus.cfg_word)
      2'd0:    pe_wr_val[31:0]  = bus.cfg_data;
      2'd1:    pe_wr_val[63:32] = bus.cfg_data;
      2'd2:    pe_wr_val[95:64] = bus.cfg_data;
      default: pe_wr_val[PE_DATA_WIDTH-1:96] = bus.cfg_data[PE_DATA_WIDTH-97:0];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (pe_we)  pe_mem[bus.cfg_ctx][pe_idx]   <= pe_wr_val;
    if (agu_we) agu_mem[bus.cfg_ctx][agu_idx] <= agu_wr_val;
  end

  assign last_in_iter = (ctx_ptr == len_q);
  assign final_iter   = (loops_q != 8'd0) && ((iter_cnt + 8'd1) == loops_q);
  assign len_clamped  = ({1'b0, bus.run_len} >= CTX_LIMIT) ? CTX_LAST : bus.run_len;

  // Context to present on the next cycle: 0 when launching from IDLE, else the successor.
  always_comb begin
    ld_ctx = '0;
    if ((state == RUN) && !last_in_iter) ld_ctx = ctx_ptr + 1'b1;
  end

  // A write landing in the same cycle as run_req is forwarded so the first RUN cycle sees it.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      ld_pe[k] = pe_mem[ld_ctx][k];
      if (pe_we && (bus.cfg_ctx == ld_ctx) && (pe_idx == 4'(k))) ld_pe[k] = pe_wr_val;
    end
    for (int k = 0; k < 3; k++) begin
      ld_agu[k] = agu_mem[ld_ctx][k];
      if (agu_we && (bus.cfg_ctx == ld_ctx) && (agu_idx == 2'(k))) ld_agu[k] = agu_wr_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      ctx_ptr   <= '0;
      iter_cnt  <= '0;
      len_q     <= '0;
      loops_q   <= '0;
      start_r   <= 1'b0;
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
      for (int k = 0; k < 9; k++) pe_q[k]  <= '0;
      for (int k = 0; k < 3; k++) agu_q[k] <= '0;
    end else begin
      cfg_err_r <= wr_acc && wr_illegal;
      done_r    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.run_req) begin
            state    <= RUN;
            len_q    <= len_clamped;
            loops_q  <= bus.loop_count;
            ctx_ptr  <= '0;
            iter_cnt <= '0;
            start_r  <= 1'b1;
            pe_q     <= ld_pe;
            agu_q    <= ld_agu;
          end
        end
        RUN: begin
          if (bus.stop || (last_in_iter && final_iter)) begin
            state    <= DONE;
            done_r   <= 1'b1;
            start_r  <= 1'b0;
            ctx_ptr  <= '0;
            iter_cnt <= '0;
            for (int k = 0; k < 9; k++) pe_q[k]  <= '0;
            for (int k = 0; k < 3; k++) agu_q[k] <= '0;
          end else begin
            ctx_ptr <= ld_ctx;
            if (last_in_iter) iter_cnt <= iter_cnt + 8'd1;
            pe_q    <= ld_pe;
            agu_q   <= ld_agu;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
